regfile_seq_ctrl: RTL
=====================

Name: regfile_seq_ctrl

Overview:
- Sequencer that drives the lab3 register file and ALU to fill a block of registers with a Fibonacci-style series: r[i] = r[i-1] + r[i-2].
- Sits inside top, between the start logic and the existing regfile/ALU instances.
- Owns every regfile address, write-enable and write-data line, plus the ALU operands and opcode.
- Exposes the last written value as result.

Parameters:
- ADDR_W, 5, regfile address width.
- DATA_W, 32, data width.
- BASE_ADDR, 1, first register written. r0 is never written.
- ALU_OP_W, 3, ALU opcode width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a run. Sampled only in IDLE.
- seed_a  in  DATA_W  value for r[BASE_ADDR].
- seed_b  in  DATA_W  value for r[BASE_ADDR+1].
- n_terms  in  ADDR_W+1  number of terms to write, including both seeds.
- ra1  out  ADDR_W  regfile read address 1.
- ra2  out  ADDR_W  regfile read address 2.
- rd1  in  DATA_W  regfile read data 1. Combinational read.
- rd2  in  DATA_W  regfile read data 2. Combinational read.
- we  out  1  regfile write enable.
- wa  out  ADDR_W  regfile write address.
- wd  out  DATA_W  regfile write data.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_op  out  ALU_OP_W  ALU opcode. Constant ALU_ADD while busy, else 0.
- alu_y  in  DATA_W  ALU result. Combinational.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- result  out  DATA_W  last value written.

Behaviour:
- Reset: on a rising clk edge with rst=1, state=IDLE.
  - All outputs are 0: we, busy, done, result, ra1, ra2, wa, wd, alu_a, alu_b, alu_op.
  - Reset overrides every other input, including mid-run. Any write in flight is dropped; we=0 from the next cycle.
- Term count:
  - n_eff = clamp(n_terms, 2, 2^ADDR_W - BASE_ADDR).
  - Latched on the start edge, together with seed_a and seed_b.
- FSM: IDLE -> INIT0 -> INIT1 -> READ -> EXEC -> WRITE -> (READ | DONE) -> IDLE.
  - IDLE: start=1 -> INIT0. Set idx = BASE_ADDR+2.
  - INIT0: we=1, wa=BASE_ADDR, wd=seed_a, result<=seed_a.
  - INIT1: we=1, wa=BASE_ADDR+1, wd=seed_b, result<=seed_b. If n_eff==2 -> DONE, else -> READ.
  - READ: ra1=idx-2, ra2=idx-1. Register rd1->alu_a and rd2->alu_b.
  - EXEC: drive alu_a/alu_b from the registers. Latch alu_y into the sum register.
  - WRITE: we=1, wa=idx, wd=sum, result<=sum. idx++. If idx == BASE_ADDR+n_eff-1 before the increment -> DONE, else -> READ.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in INIT0 through WRITE. busy=0 in IDLE and DONE.
- Latency: done is high in cycle 2+3*(n_eff-2)+1 after the start edge. The start edge is cycle 0.
- Arithmetic: the sum wraps modulo 2^DATA_W. No overflow flag.
- start while busy or in DONE is ignored; it is not queued.
- we is high only in INIT0, INIT1 and WRITE, and at most one write happens per cycle.
- ra1, ra2, alu_a, alu_b hold their values outside the states that update them.
- result holds its value after done until the next run's INIT0 or reset.

Decomposition:
- Package regfile_seq_pkg:
  - state enum: IDLE, INIT0, INIT1, READ, EXEC, WRITE, DONE.
  - ALU_ADD opcode constant (matches the lab3 ALU encoding).
  - clamp bounds.
- Sub-module seq_idx_counter: index register with load, increment and terminal-compare. Used for idx and the last-index test.

Test Plan:
- Basic run: rst=1 then 0; seed_a=1, seed_b=1, n_terms=10, start pulse.
  - Writes r1..r10 = 1,1,2,3,5,8,13,21,34,55.
  - done pulses in cycle 27. result=55. busy=0 afterwards.
- Wrap-around: seed_a=32'hFFFFFFFF, seed_b=1, n_terms=3.
  - r3 = 0, result = 0.
  - done in cycle 6.
- Clamp low and high:
  - n_terms=0: only r1 and r2 are written; done in cycle 3.
  - n_terms=40: the last write is to r31; wa never exceeds 31; done in cycle 90.
- Start while busy: second start pulse during EXEC with different seeds.
  - Ignored. Writes match the first run only. Exactly one done pulse.
- Reset mid-run: rst=1 for one cycle during a WRITE state.
  - Next cycle: we=0, busy=0, result=0, state IDLE.
  - A subsequent start with seeds 2,3 and n_terms=4 writes 2,3,5,8 to r1..r4.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the Fibonacci regfile sequencer.
package regfile_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT0,
        INIT1,
        READ,
        EXEC,
        WRITE,
        DONE
    } state_e;

    // lab3 ALU control encoding for addition
    localparam logic [2:0] ALU_ADD = 3'b010;

    localparam int N_TERMS_MIN = 2;

    function automatic int n_terms_max(input int addr_w, input int base_addr);
        return (1 << addr_w) - base_addr;
    endfunction

endpackage

// File: rtl/seq_idx_counter.sv
// Register index counter: load, increment, and compare against a terminal index.
module seq_idx_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] idx_o,
    output logic         is_last_o
);

    logic [W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (load_i) begin
            idx_q <= load_val_i;
        end else if (inc_i) begin
            idx_q <= idx_q + W'(1);
        end
    end

    assign idx_o     = idx_q;
    assign is_last_o = (idx_q == last_i);

endmodule

// File: rtl/regfile_seq_ctrl.sv
// Drives regfile and ALU to fill r[BASE_ADDR..] with r[i] = r[i-1] + r[i-2].
// Two seed writes, then three cycles (read, execute, write) per computed term.
module regfile_seq_ctrl
    import regfile_seq_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = 1,
    parameter int ALU_OP_W  = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed_a,
    input  logic [DATA_W-1:0]   seed_b,
    input  logic [ADDR_W:0]     n_terms,
    output logic [ADDR_W-1:0]   ra1,
    output logic [ADDR_W-1:0]   ra2,
    input  logic [DATA_W-1:0]   rd1,
    input  logic [DATA_W-1:0]   rd2,
    output logic                we,
    output logic [ADDR_W-1:0]   wa,
    output logic [DATA_W-1:0]   wd,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_y,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result
);

    localparam logic [ADDR_W-1:0] MAX_T  = ADDR_W'(n_terms_max(ADDR_W, BASE_ADDR));
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_e              state_q;
    logic [ADDR_W-1:0]   n_eff;
    logic [ADDR_W-1:0]   last_d, last_q;
    logic [DATA_W-1:0]   seed_b_q;
    logic [ADDR_W-1:0]   ra1_q, ra2_q, wa_q;
    logic [DATA_W-1:0]   wd_q, alu_a_q, alu_b_q, result_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                we_q, busy_q, done_q;
    logic [ADDR_W-1:0]   idx;
    logic                idx_is_last;
    logic                run_load;

    // Clamp is done at full n_terms width so oversized requests saturate.
    always_comb begin
        n_eff = n_terms[ADDR_W-1:0];
        if (n_terms < (ADDR_W+1)'(N_TERMS_MIN)) begin
            n_eff = ADDR_W'(N_TERMS_MIN);
        end else if (n_terms > {1'b0, MAX_T}) begin
            n_eff = MAX_T;
        end
        last_d = BASE_A + n_eff - ADDR_W'(1);
    end

    assign run_load = (state_q == IDLE) && start;

    seq_idx_counter #(
        .W(ADDR_W)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (run_load),
        .load_val_i (BASE_A + ADDR_W'(2)),
        .inc_i      (state_q == WRITE),
        .last_i     (last_q),
        .idx_o      (idx),
        .is_last_o  (idx_is_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= '0;
            seed_b_q <= '0;
            ra1_q    <= '0;
            ra2_q    <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= INIT0;
                        last_q   <= last_d;
                        seed_b_q <= seed_b;
                        busy_q   <= 1'b1;
                        alu_op_q <= ALU_OP_W'(ALU_ADD);
                        we_q     <= 1'b1;
                        wa_q     <= BASE_A;
                        wd_q     <= seed_a;
                        result_q <= seed_a;
                    end
                end
                INIT0: begin
                    state_q  <= INIT1;
                    we_q     <= 1'b1;
                    wa_q     <= BASE_A + ADDR_W'(1);
                    wd_q     <= seed_b_q;
                    result_q <= seed_b_q;
                end
                INIT1: begin
                    if (last_q == BASE_A + ADDR_W'(1)) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        alu_op_q <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= READ;
                        ra1_q   <= idx - ADDR_W'(2);
                        ra2_q   <= idx - ADDR_W'(1);
                    end
                end
                READ: begin
                    state_q <= EXEC;
                    alu_a_q <= rd1;
                    alu_b_q <= rd2;
                end
                EXEC: begin
                    // wd doubles as the sum register for the write cycle
                    state_q  <= WRITE;
                    we_q     <= 1'b1;
                    wa_q     <= idx;
                    wd_q     <= alu_y;
                    result_q <= alu_y;
                end
                WRITE: begin
                    if (idx_is_last) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        alu_op_q <= '0;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= READ;
                        ra1_q   <= idx - ADDR_W'(1);
                        ra2_q   <= idx;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ra1    = ra1_q;
    assign ra2    = ra2_q;
    assign we     = we_q;
    assign wa     = wa_q;
    assign wd     = wd_q;
    assign alu_a  = alu_a_q;
    assign alu_b  = alu_b_q;
    assign alu_op = alu_op_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
